// File: rtl/conv_pkg.sv
// Shared kernel geometry, pixel/window types and scheduler state encoding
// for the streaming convolution slice.
package conv_pkg;

  localparam int KERNEL_SIZE = 3;
  localparam int PX_SIZE     = 8;
  localparam int NUM_INPUTS  = KERNEL_SIZE * KERNEL_SIZE;
  // Scale applied to the multiply-accumulate result before truncation to a pixel.
  localparam int PE_SHIFT    = 3;

  typedef logic [PX_SIZE-1:0] px_t;
  typedef px_t [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0] window_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_K,
    STREAM,
    DONE
  } state_e;

endpackage

// File: rtl/conv_sched_line_window.sv
// K-1 line buffers (depth IMG_W) feeding a KxK window that shifts toward
// higher column index on every accepted pixel.
module line_window
  import conv_pkg::*;
#(
  parameter int IMG_W = 8
) (
  input  logic    clk,
  input  logic    shift_en,
  input  px_t     px_in,
  output window_t window
);

  px_t                                   lb [1:KERNEL_SIZE-1][IMG_W];
  px_t [KERNEL_SIZE-1:0][KERNEL_SIZE-1:1] win_q;
  px_t [KERNEL_SIZE-1:0]                 feed;

  always_comb begin
    feed    = '0;
    feed[0] = px_in;
    for (int unsigned r = 1; r < KERNEL_SIZE; r++) begin
      feed[r] = lb[r][IMG_W-1];
    end
  end

  // Column 0 is the live feed rather than a register, so the window seen
  // during an accept already contains the incoming pixel.
  always_comb begin
    window = '0;
    for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
      window[r][0] = feed[r];
      for (int unsigned c = 1; c < KERNEL_SIZE; c++) begin
        window[r][c] = win_q[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) begin
      for (int unsigned r = 1; r < KERNEL_SIZE; r++) begin
        lb[r][0] <= feed[r-1];
        for (int unsigned i = 1; i < IMG_W; i++) begin
          lb[r][i] <= lb[r][i-1];
        end
      end
      for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
        win_q[r][1] <= feed[r];
        for (int unsigned c = 2; c < KERNEL_SIZE; c++) begin
          win_q[r][c] <= win_q[r][c-1];
        end
      end
    end
  end

endmodule

// File: rtl/proc_elem.sv
// Combinational processing element: element-wise window x kernel MAC,
// scaled down by PE_SHIFT and truncated to one pixel.
module proc_elem
  import conv_pkg::*;
#(
  parameter int INPUT_CHANNELS = 1
) (
  input  window_t window,
  input  window_t kernel,
  output px_t     img_out
);

  localparam int ACC_W = 2 * PX_SIZE + $clog2(NUM_INPUTS * INPUT_CHANNELS) + 1;

  logic [ACC_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
      for (int unsigned c = 0; c < KERNEL_SIZE; c++) begin
        acc = acc + ACC_W'(window[r][c]) * ACC_W'(kernel[r][c]);
      end
    end
  end

  assign img_out = px_t'(acc >> PE_SHIFT);

endmodule

// File: rtl/conv_sched.sv
// Streams a raster image through one proc_elem: serial kernel load, then one
// registered output pixel per fully-inside window position (no padding).
module conv_sched
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               k_valid,
  output logic               k_ready,
  input  logic [PX_SIZE-1:0] k_data,
  input  logic               px_valid,
  output logic               px_ready,
  input  logic [PX_SIZE-1:0] px_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PX_SIZE-1:0] out_data,
  output logic               out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int KW = $clog2(NUM_INPUTS);

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL_SIZE - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(NUM_INPUTS - 1);

  state_e        state, state_nxt;
  logic [KW-1:0] k_cnt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          all_in;
  window_t       kernel;
  window_t       window;
  px_t           pe_out;
  logic          k_acc, px_acc, emit, last_px;

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    k_ready   = (state == LOAD_K);
    px_ready  = (state == STREAM) && (!out_valid || out_ready);
    k_acc     = k_valid && k_ready;
    px_acc    = px_valid && px_ready;
    last_px   = (row == ROW_LAST) && (col == COL_LAST);
    emit      = px_acc && (row >= ROW_FIRST) && (col >= COL_FIRST);
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD_K;
      LOAD_K:  if (k_acc && k_cnt == K_LAST) state_nxt = STREAM;
      STREAM:  if (all_in && !out_valid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k_cnt     <= '0;
      col       <= '0;
      row       <= '0;
      all_in    <= 1'b0;
      kernel    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && start) begin
        k_cnt  <= '0;
        col    <= '0;
        row    <= '0;
        all_in <= 1'b0;
      end

      // Word k lands at [K-1-k/K][K-1-k%K], i.e. flat index NUM_INPUTS-1-k.
      if (k_acc) begin
        for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
          for (int unsigned c = 0; c < KERNEL_SIZE; c++) begin
            if (k_cnt == KW'(NUM_INPUTS - 1 - (r * KERNEL_SIZE + c))) kernel[r][c] <= k_data;
          end
        end
        k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + KW'(1);
      end

      if (px_acc) begin
        if (col == COL_LAST) begin
          col <= '0;
          if (row != ROW_LAST) row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (last_px) all_in <= 1'b1;
      end

      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= pe_out;
        out_last  <= last_px;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  line_window #(
    .IMG_W(IMG_W)
  ) u_line_window (
    .clk     (clk),
    .shift_en(px_acc),
    .px_in   (px_data),
    .window  (window)
  );

  proc_elem #(
    .INPUT_CHANNELS(1)
  ) u_proc_elem (
    .window (window),
    .kernel (kernel),
    .img_out(pe_out)
  );

endmodule
